led_fader: RTL and testbench

LED_FADER -- requirements
Module: led_fader

---
 rtl/led_fader.sv | 76 +++++++
 tb/tb_led_fader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// led_fader: ramps LED brightness one step per prescaler tick toward a target and drives it as PWM.
// Ports:
//   clk        16 MHz clock, all logic on the rising edge
//   resetn     asynchronous active-low reset
//   target     requested brightness, registered once before use
//   breathe    autonomous 0->255->0 sweep request (used only with LED_FADER_BREATHE_EN)
//   pwm_out    registered PWM drive, high = LED on
//   level      current brightness
//   at_target  registered flag, level equals the effective target
// Optional feature macro: LED_FADER_BREATHE_EN enables breathe mode.
module led_fader #(
  parameter int PRESCALE_BITS = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] target,
  input  logic       breathe,
  output logic       pwm_out,
  output logic [7:0] level,
  output logic       at_target
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  localparam logic [PRESCALE_BITS-1:0] PRESC_ONE = 1;
  state_t state_q, state_d;
  logic [PRESCALE_BITS-1:0] presc_q;
  logic [7:0] pwm_cnt_q, target_q, level_q, level_d, eff_target, eff_target_d;
  logic pwm_out_q, at_target_q, tick;
  assign tick = &presc_q;
`ifdef LED_FADER_BREATHE_EN
  logic dir_q, dir_d;
  // The sweep direction flips on the tick where level lands on the current endpoint.
  always_comb begin
    eff_target = breathe ? (dir_q ? 8'd0 : 8'd255) : target_q;
    dir_d = breathe & (dir_q ^ (tick & (level_d == eff_target)));
    eff_target_d = breathe ? (dir_d ? 8'd0 : 8'd255) : target_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) dir_q <= 1'b0;
    else dir_q <= dir_d;
`else
  logic unused_breathe;
  assign unused_breathe = breathe;
  assign eff_target = target_q;
  assign eff_target_d = target_q;
`endif
  // Stepping only while strictly below/above the target makes wrap impossible at 0 and 255.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (tick) begin
      state_d = level_q < eff_target ? UP : level_q > eff_target ? DOWN : IDLE;
      level_d = level_q < eff_target ? level_q + 8'd1 : level_q > eff_target ? level_q - 8'd1 : level_q;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      presc_q     <= '0;
      pwm_cnt_q   <= 8'd0;
      target_q    <= 8'd0;
      level_q     <= 8'd0;
      state_q     <= IDLE;
      pwm_out_q   <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      presc_q     <= presc_q + PRESC_ONE;
      pwm_cnt_q   <= pwm_cnt_q + 8'd1;
      target_q    <= target;
      level_q     <= level_d;
      state_q     <= state_d;
      pwm_out_q   <= level_q > pwm_cnt_q;
      at_target_q <= level_d == eff_target_d;
    end
  assign pwm_out   = pwm_out_q;
  assign level     = level_q;
  assign at_target = at_target_q;
endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed scoreboard bench for led_fader with a 16-clock ramp tick.
module tb_led_fader;
  logic clk = 1'b0, resetn = 1'b0, breathe = 1'b0;
  logic [7:0] target = 8'd0;
  logic pwm_out, at_target;
  logic [7:0] level;
  int total = 0, bad = 0, cyc, n;
  typedef struct {string tag; int v;} exp_t;
  exp_t sb[$];
  led_fader #(.PRESCALE_BITS(4)) dut (
    .clk(clk), .resetn(resetn), .target(target), .breathe(breathe),
    .pwm_out(pwm_out), .level(level), .at_target(at_target)
  );
  always #5 clk = ~clk;
  // clocks since reset release; a ramp tick lands on every 16th edge
  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic push(input string t, input int v);
    sb.push_back('{t, v});
  endtask
  task automatic pop_chk(input int obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: got %0d expected an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s: got %0d expected %0d", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic clocks(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask
  task automatic ticks(input int k);
    repeat (k) do begin @(posedge clk); #1; end while (cyc % 16 != 0);
  endtask
  task automatic pwm_count(output int c);
    c = 0;
    repeat (256) begin @(posedge clk); #1; if (pwm_out) c++; end
  endtask
  initial begin
    clocks(3);
    push("rst_level", 0); pop_chk(int'(level));
    push("rst_at", 1); pop_chk(int'(at_target));
    push("rst_pwm", 0); pop_chk(int'(pwm_out));
    @(negedge clk) resetn = 1'b1;
    ticks(2);
    push("idle_level", 0); pop_chk(int'(level));
    push("idle_pwm_cnt", 0); pwm_count(n); pop_chk(n);
    ticks(1);
    target = 8'd10;
    clocks(2);
    push("ramp_at_low", 0); pop_chk(int'(at_target));
    for (int i = 1; i <= 10; i++) begin
      push($sformatf("ramp10_level_%0d", i), i);
      push($sformatf("ramp10_at_%0d", i), i == 10 ? 1 : 0);
      ticks(1);
      pop_chk(int'(level));
      pop_chk(int'(at_target));
    end
    push("pwm10_cnt", 10); pwm_count(n); pop_chk(n);
    ticks(1);
    target = 8'd200;
    push("up_to_50", 50); ticks(40); pop_chk(int'(level));
    target = 8'd20;
    push("reverse_49", 49); ticks(1); pop_chk(int'(level));
    push("settle_20", 20); push("settle_20_at", 1);
    ticks(29); pop_chk(int'(level)); pop_chk(int'(at_target));
    push("hold_20", 20); ticks(3); pop_chk(int'(level));
    target = 8'd0;
    push("down_to_0", 0); ticks(20); pop_chk(int'(level));
    target = 8'd255;
    push("swing_254", 254); ticks(254); pop_chk(int'(level));
    push("swing_255", 255); push("swing_255_at", 1);
    ticks(1); pop_chk(int'(level)); pop_chk(int'(at_target));
    push("sat_255", 255); ticks(5); pop_chk(int'(level));
    push("pwm255_cnt", 255); pwm_count(n); pop_chk(n);
    ticks(1);
    target = 8'd0;
    push("fall_0", 0); push("fall_0_at", 1);
    ticks(255); pop_chk(int'(level)); pop_chk(int'(at_target));
    push("sat_0", 0); ticks(5); pop_chk(int'(level));
    target = 8'd200;
    push("pre_rst_100", 100); ticks(100); pop_chk(int'(level));
    #40 resetn = 1'b0;
    #1;
    push("async_rst_level", 0); pop_chk(int'(level));
    push("async_rst_pwm", 0); pop_chk(int'(pwm_out));
    push("async_rst_at", 1); pop_chk(int'(at_target));
    clocks(2);
    @(negedge clk) resetn = 1'b1;
    push("post_rst_edge15", 0); clocks(15); pop_chk(int'(level));
    push("post_rst_edge16", 1); clocks(1); pop_chk(int'(level));
    target = 8'd5;
    push("post_rst_5", 5); ticks(4); pop_chk(int'(level));
    breathe = 1'b1;
`ifdef LED_FADER_BREATHE_EN
    push("breathe_top", 255); ticks(250); pop_chk(int'(level));
    push("breathe_turn", 254); ticks(1); pop_chk(int'(level));
    push("breathe_bottom", 0); ticks(254); pop_chk(int'(level));
    push("breathe_rise", 1); ticks(1); pop_chk(int'(level));
    breathe = 1'b0;
    push("breathe_off_level", 5); push("breathe_off_at", 1);
    ticks(10); pop_chk(int'(level)); pop_chk(int'(at_target));
`else
    push("breathe_ignored_level", 5); push("breathe_ignored_at", 1);
    ticks(20); pop_chk(int'(level)); pop_chk(int'(at_target));
    breathe = 1'b0;
`endif
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
